// File: rtl/pr_pkg.sv
// Shared definitions for the PageRank rank datapath: default widths, rank word
// type, saturation ceiling and the clear-sweep FSM states.
package pr_pkg;

    localparam int PR_DATA_W = 21;
    localparam int PR_ADDR_W = 5;

    typedef logic [PR_DATA_W-1:0] rank_t;

    localparam rank_t RANK_MAX = {PR_DATA_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/pr_sat_add.sv
// Unsigned saturating adder: clamps to all-ones on carry-out and reports it.
// Shared with the edge-contribution engine.
module pr_sat_add
    import pr_pkg::*;
#(
    parameter int DATA_W = PR_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_sat
);

    logic [DATA_W:0] w_sum;

    // One extra bit catches the carry that triggers the clamp.
    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        o_sat = w_sum[DATA_W];
        if (w_sum[DATA_W]) begin
            o_sum = {DATA_W{1'b1}};
        end else begin
            o_sum = w_sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/pr_rank_regfile.sv
// Multi-read-port rank store with overwrite / saturating accumulate writes and a
// sequential clear sweep. Optional macro RF_BYPASS_EN makes colliding reads write-first.
module pr_rank_regfile
    import pr_pkg::*;
#(
    parameter int DATA_W = PR_DATA_W,
    parameter int ADDR_W = PR_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_start,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic                     wr_acc,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     sat_flag
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_sat;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_wr_fire;
    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_sum;
    logic              w_add_sat;
    logic [DATA_W-1:0] w_wr_val;

    assign w_cur = r_mem[wr_addr];

    pr_sat_add #(.DATA_W(DATA_W)) u_sat_add (
        .i_a   (w_cur),
        .i_b   (wr_data),
        .o_sum (w_sum),
        .o_sat (w_add_sat)
    );

    // Write qualification: a clear request in the same cycle drops the write.
    always_comb begin
        w_idle    = (r_state == ST_IDLE);
        w_wr_fire = w_idle & wr_en & ~clear_start;
        if (wr_acc) begin
            w_wr_val = w_sum;
        end else begin
            w_wr_val = wr_data;
        end
    end

    // Sweep FSM, pointer and sticky saturation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= {ADDR_W{1'b0}};
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clear_start) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= {ADDR_W{1'b0}};
                        r_sat   <= 1'b0;
                    end else if (w_wr_fire && wr_acc && w_add_sat) begin
                        r_sat <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Storage has no reset net so it can map to RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= {DATA_W{1'b0}};
        end else if (w_wr_fire) begin
            r_mem[wr_addr] <= w_wr_val;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rv;
        logic              r_v;
        logic [DATA_W-1:0] r_d;

        assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

        // Read source: array contents, or the post-write value when forwarding is built in.
        always_comb begin
`ifdef RF_BYPASS_EN
            if (w_wr_fire && (wr_addr == w_ra)) begin
                w_rv = w_wr_val;
            end else begin
                w_rv = r_mem[w_ra];
            end
`else
            w_rv = r_mem[w_ra];
`endif
        end

        // Registered read port; idle slots return zero.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_v <= 1'b0;
                r_d <= {DATA_W{1'b0}};
            end else if (w_idle && rd_en[k]) begin
                r_v <= 1'b1;
                r_d <= w_rv;
            end else begin
                r_v <= 1'b0;
                r_d <= {DATA_W{1'b0}};
            end
        end

        assign rd_valid[k]                  = r_v;
        assign rd_data[k*DATA_W +: DATA_W]  = r_d;
    end

    assign busy     = (r_state == ST_CLEAR);
    assign sat_flag = r_sat;

endmodule

// File: doc/pr_rank_regfile.md
Name: pr_rank_regfile

Overview:
- Parametrised, multi-read-port rank storage for the PageRank datapath.
- Holds one unsigned rank word per node.
- Supports plain write and saturating accumulate-write, so contributions can be summed in place.
- Clears storage with a sequential sweep FSM, so the array has no reset net and maps to RAM. Sits between the edge-contribution engine (write side) and the rank-normalisation stage (read side).

Parameters:
DATA_W, 21, width of each rank word (unsigned).
ADDR_W, 5, address width; depth = 2**ADDR_W entries.
NUM_RD, 2, number of independent read ports (1..4).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
clear_start  input  1  single-cycle pulse; starts a clear sweep.
busy  output  1  high while a sweep is in progress.
wr_en  input  1  write request.
wr_acc  input  1  0 = overwrite, 1 = saturating accumulate into the addressed entry.
wr_addr  input  ADDR_W  write address.
wr_data  input  DATA_W  write data or addend.
rd_en  input  NUM_RD  per-port read request.
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k is at [k*ADDR_W +: ADDR_W].
rd_data  output  NUM_RD*DATA_W  packed registered read data.
rd_valid  output  NUM_RD  per-port: rd_data valid this cycle.
sat_flag  output  1  sticky; set when any accumulate saturated.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: busy=1, rd_data=0, rd_valid=0, sat_flag=0, FSM=CLEAR, sweep pointer=0. Storage is not reset directly.
- FSM states:
  - CLEAR: writes 0 to entry[ptr], then ptr++. At ptr = 2**ADDR_W-1, writes the last entry and goes to IDLE next cycle. busy=1 throughout. A sweep therefore takes exactly 2**ADDR_W cycles after reset deasserts.
  - IDLE: busy=0. On clear_start: ptr=0, sat_flag<=0, go to CLEAR (busy=1 next cycle).
- clear_start while in CLEAR is ignored; the sweep is not restarted.
- Reset asserted mid-sweep restarts the sweep at ptr=0.
- In CLEAR, wr_en and rd_en are ignored: no storage change, rd_valid=0, rd_data=0.
- clear_start and wr_en in the same IDLE cycle: the write is dropped and the clear wins.
- Overwrite (wr_en=1, wr_acc=0): entry[wr_addr] <= wr_data at the clock edge.
- Accumulate (wr_en=1, wr_acc=1): entry <= min(entry + wr_data, 2**DATA_W-1), computed with a DATA_W+1 bit sum.
  - On carry-out, the entry is clamped to all-ones and sat_flag<=1.
  - Back-to-back accumulates to the same address must sum correctly (single-cycle RMW, no pipeline hazard).
- Read port k has 1-cycle latency.
  - rd_en[k]=1 in cycle t gives rd_data[k]=entry[rd_addr[k]] and rd_valid[k]=1 in cycle t+1.
  - rd_en[k]=0 gives rd_data[k]=0 and rd_valid[k]=0 in t+1.
- Multiple ports reading the same address return identical data.
- Read and write to the same address in the same cycle: old data is returned (read-first), unless RF_BYPASS_EN is defined.
- Address wrap-around does not occur; every address in range is valid.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read that collides with a same-cycle write returns the post-write value (wr_data for overwrite, saturated sum for accumulate), i.e. write-first.
- Undefined: read-first as above. There is no forwarding logic at all.

Decomposition:
- Shared package pr_pkg: default DATA_W/ADDR_W, the rank word typedef rank_t, RANK_MAX constant, and FSM state enum (ST_IDLE, ST_CLEAR).
- Natural sub-module: pr_sat_add (DATA_W-wide saturating adder; outputs sum and sat). It is reused by the contribution engine.

Test Plan:
- Reset, then idle 32 cycles: busy high exactly 32 cycles. Afterwards read all 32 addresses on both ports: all 0, rd_valid 1 cycle after rd_en.
- Write 0x1ABCD to address 7; next cycle read addr 7 on port0 and addr 7 on port1: both return 0x1ABCD; sat_flag=0.
- Accumulate 1000 to address 3 three consecutive cycles from 0: read returns 3000. Then accumulate 0x1FFFFF: entry=0x1FFFFF, sat_flag=1.
- Same-cycle write 0x55 to address 9 (old value 0x11) and read 9: returns 0x11 without RF_BYPASS_EN, 0x55 with it.
- Write addr 2=0x100, then clear_start together with a write to addr 4: busy for 32 cycles, the write is dropped, reads during the sweep are invalid, and afterwards addr 2 and addr 4 read 0 and sat_flag=0.
- Assert reset at sweep ptr=10, release: busy is high for a full 32 cycles again, and all entries read 0.
